// File: rtl/param_load_buffer_if.sv
// Byte-load and frame-output bundle for param_load_buffer.
// slave = the buffer itself, master = whoever feeds bytes and drains frames.
interface param_load_buffer_if #(
    parameter int NUM_BYTES = 33,
    parameter int BYTE_W    = 8,
    parameter int ADDR_W    = 6
);
    logic [BYTE_W-1:0]           data_in;
    logic                        in_valid;
    logic                        in_ready;
    logic                        addr_mode;
    logic [ADDR_W-1:0]           addr;
    logic                        commit;
    logic                        clear;
    logic [NUM_BYTES*BYTE_W-1:0] data_out;
    logic                        out_valid;
    logic                        out_ready;
    logic [ADDR_W-1:0]           byte_count;
    logic                        addr_err;

    modport slave (
        input  data_in, in_valid, addr_mode, addr, commit, clear, out_ready,
        output in_ready, data_out, out_valid, byte_count, addr_err
    );

    modport master (
        output data_in, in_valid, addr_mode, addr, commit, clear, out_ready,
        input  in_ready, data_out, out_valid, byte_count, addr_err
    );
endinterface

// File: rtl/param_load_buffer.sv
// Double-banked frame loader: bytes land in L, a completed frame moves to O the same edge (O valid next cycle).
// in_ready drops while a finished frame waits in L behind an unconsumed O; out side is valid/ready.
module param_load_buffer #(
    parameter int NUM_BYTES = 33,
    parameter int BYTE_W    = 8,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    param_load_buffer_if.slave   bus
);
    localparam int                FRAME_W  = NUM_BYTES * BYTE_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);
    localparam logic [ADDR_W-1:0] NUM_IDX  = ADDR_W'(NUM_BYTES);

    typedef enum logic {
        LOAD = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [FRAME_W-1:0]  load_q;
    logic [FRAME_W-1:0]  load_nxt;
    logic [FRAME_W-1:0]  out_q;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   wr_ptr_nxt;
    logic                out_valid_q;
    logic                addr_err_q;

    logic                in_ready;
    logic                xfer_load;
    logic                xfer_pend;

    logic                wr_acc;
    logic                stream_wr;
    logic                addr_wr;
    logic                addr_ok;
    logic                commit_acc;
    logic                stream_last;
    logic                frame_done;
    logic                consume;
    logic                byte_we;
    logic [ADDR_W-1:0]   wr_idx;

    // clear wins over any same-cycle write or commit
    assign wr_acc      = bus.in_valid && in_ready && !bus.clear;
    assign stream_wr   = wr_acc && !bus.addr_mode;
    assign addr_wr     = wr_acc && bus.addr_mode;
    assign addr_ok     = (bus.addr < NUM_IDX);
    assign commit_acc  = bus.commit && in_ready && bus.addr_mode && !bus.clear;
    assign stream_last = stream_wr && (wr_ptr == LAST_IDX);
    assign frame_done  = stream_last || commit_acc;
    assign consume     = out_valid_q && bus.out_ready;
    assign byte_we     = stream_wr || (addr_wr && addr_ok);
    assign wr_idx      = bus.addr_mode ? bus.addr : wr_ptr;

    // Load bank with this cycle's byte merged in, so a closing write lands in the frame.
    always_comb begin
        load_nxt = load_q;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_we && (wr_idx == ADDR_W'(i))) begin
                load_nxt[i*BYTE_W +: BYTE_W] = bus.data_in;
            end
        end
    end

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        if (bus.clear) begin
            wr_ptr_nxt = '0;
        end else if (stream_wr) begin
            wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (frame_done && out_valid_q && !bus.out_ready) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (bus.clear || consume) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        xfer_load = 1'b0;
        xfer_pend = 1'b0;
        case (state)
            LOAD: begin
                in_ready  = 1'b1;
                xfer_load = frame_done && (!out_valid_q || consume);
            end
            PEND: begin
                xfer_pend = consume && !bus.clear;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            load_q      <= '0;
            out_q       <= '0;
            wr_ptr      <= '0;
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            load_q     <= load_nxt;
            wr_ptr     <= wr_ptr_nxt;
            addr_err_q <= addr_wr && !addr_ok;
            if (xfer_load) begin
                out_q <= load_nxt;
            end else if (xfer_pend) begin
                out_q <= load_q;
            end
            if (xfer_load || xfer_pend) begin
                out_valid_q <= 1'b1;
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.data_out   = out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.byte_count = wr_ptr;
    assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_param_load_buffer.sv
// Directed bench for param_load_buffer with a frame scoreboard checked on every output handshake.
module tb_param_load_buffer;
    localparam int NB = 33;
    localparam int BW = 8;
    localparam int AW = 6;
    localparam int FW = NB * BW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    param_load_buffer_if #(.NUM_BYTES(NB), .BYTE_W(BW), .ADDR_W(AW)) bus ();

    param_load_buffer #(.NUM_BYTES(NB), .BYTE_W(BW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [BW-1:0]   ml [NB];
    int              ptr = 0;
    logic [FW-1:0]   exp_q [$];
    logic [FW-1:0]   frame_a;
    logic            ov_before;

    function automatic logic [FW-1:0] pack();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < NB; i++) f[i*BW +: BW] = ml[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic [BW-1:0] b);
        int n;
        n = 0;
        bus.addr_mode = 1'b0;
        bus.data_in   = b;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $error("FAIL stall_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        step();
        bus.in_valid = 1'b0;
        ml[ptr] = b;
        if (ptr == NB - 1) begin
            ptr = 0;
            exp_q.push_back(pack());
        end else begin
            ptr++;
        end
    endtask

    task automatic awrite(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic v, input logic c);
        bus.addr_mode = 1'b1;
        bus.addr      = a;
        bus.data_in   = d;
        bus.in_valid  = v;
        bus.commit    = c;
        step();
        bus.in_valid  = 1'b0;
        bus.commit    = 1'b0;
        bus.addr_mode = 1'b0;
        if (v && (int'(a) < NB)) ml[a] = d;
        if (c) exp_q.push_back(pack());
    endtask

    // Scoreboard: every accepted output frame must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_frame: observed %0h with no frame expected", bus.data_out);
            end else begin
                chk("frame", bus.data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in   = '0;
        bus.in_valid  = 1'b0;
        bus.addr_mode = 1'b0;
        bus.addr      = '0;
        bus.commit    = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NB; i++) ml[i] = '0;

        // reset state
        step();
        step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_byte_count", bus.byte_count, 0);
        chk("rst_addr_err", bus.addr_err, 0);
        rst = 1'b1;

        // streaming fill with a free output bank
        bus.out_ready = 1'b1;
        for (int i = 0; i < NB; i++) stream(BW'(i));
        chk("fill_out_valid", bus.out_valid, 1);
        chk("fill_byte0", bus.data_out[7:0], 8'h00);
        chk("fill_byte32", bus.data_out[263:256], 8'h20);
        chk("fill_byte_count", bus.byte_count, 0);
        step();
        chk("fill_consumed", bus.out_valid, 0);

        // backpressure: second frame parks in PEND
        bus.out_ready = 1'b0;
        for (int i = 0; i < NB; i++) stream(BW'(8'h11 + i));
        frame_a = pack();
        chk("bp_a_valid", bus.out_valid, 1);
        for (int i = 0; i < NB; i++) stream(BW'(8'h21 + i));
        chk("bp_pend_in_ready", bus.in_ready, 0);
        bus.addr_mode = 1'b0;
        bus.data_in   = 8'h99;
        bus.in_valid  = 1'b1;
        step();
        step();
        chk("bp_stall_in_ready", bus.in_ready, 0);
        chk("bp_stall_byte_count", bus.byte_count, 0);
        chk("bp_stable_data", bus.data_out, frame_a);
        chk("bp_stable_valid", bus.out_valid, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_b_data", bus.data_out, pack());
        chk("bp_b_in_ready", bus.in_ready, 1);
        chk("bp_b_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_drained", bus.out_valid, 0);

        // addressed patch of the previous frame, write and commit together
        awrite(6'd5, 8'hAB, 1'b1, 1'b1);
        chk("patch_valid", bus.out_valid, 1);
        chk("patch_byte5", bus.data_out[47:40], 8'hAB);
        chk("patch_frame", bus.data_out, pack());
        chk("patch_byte_count", bus.byte_count, 0);
        step();
        awrite(6'd0, 8'h5A, 1'b1, 1'b0);
        awrite(6'd0, 8'h00, 1'b0, 1'b1);
        chk("commit_only_byte0", bus.data_out[7:0], 8'h5A);
        step();

        // out-of-range address
        awrite(6'd40, 8'hEE, 1'b1, 1'b0);
        chk("bad_addr_err", bus.addr_err, 1);
        step();
        chk("bad_addr_pulse", bus.addr_err, 0);
        awrite(6'd0, 8'h00, 1'b0, 1'b1);
        step();

        // clear mid-frame
        for (int i = 0; i < 10; i++) stream(BW'(8'h80 + i));
        chk("clr_pre_count", bus.byte_count, 10);
        ov_before = bus.out_valid;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        ptr = 0;
        chk("clr_byte_count", bus.byte_count, 0);
        chk("clr_out_valid", bus.out_valid, ov_before);
        for (int i = 0; i < NB; i++) stream(BW'(8'hC0 + i));
        step();
        bus.addr_mode = 1'b1;
        bus.addr      = 6'd3;
        bus.data_in   = 8'h77;
        bus.in_valid  = 1'b1;
        bus.commit    = 1'b1;
        bus.clear     = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.commit    = 1'b0;
        bus.clear     = 1'b0;
        bus.addr_mode = 1'b0;
        chk("clr_commit_valid", bus.out_valid, 0);
        chk("clr_commit_err", bus.addr_err, 0);
        awrite(6'd0, 8'h00, 1'b0, 1'b1);
        step();

        // reset while a frame is pending
        bus.out_ready = 1'b0;
        for (int i = 0; i < NB; i++) stream(BW'(8'h01 + i));
        for (int i = 0; i < NB; i++) stream(BW'(8'h40 + i));
        chk("rpend_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NB; i++) ml[i] = '0;
        ptr = 0;
        chk("rpend_out_valid", bus.out_valid, 0);
        chk("rpend_in_ready_after", bus.in_ready, 1);
        chk("rpend_data_out", bus.data_out, 0);
        chk("rpend_byte_count", bus.byte_count, 0);
        bus.out_ready = 1'b1;
        awrite(6'd0, 8'h00, 1'b0, 1'b1);
        chk("rpend_zero_frame", bus.data_out, 0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/param_load_buffer.md
# param_load_buffer

Parametrised, double-banked byte loader for the AES datapath: it collects a frame of NUM_BYTES bytes over a byte-wide interface and presents it as one flat word. Frames are loaded either by streaming with an auto-incrementing pointer or by explicit addressing with a commit. A completed frame moves into an output bank with a valid/ready handshake. The next frame can load while the previous one waits downstream, and the block applies backpressure when both banks are occupied.

## Interface
- NUM_BYTES, 33: bytes per frame, must be at least 2.
- BYTE_W, 8: bits per byte.
- ADDR_W, 6: address and pointer width, must satisfy 2^ADDR_W > NUM_BYTES.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-low (rst==0 resets at the clock edge).
- data_in  input  BYTE_W  byte to write.
- in_valid  input  1  data_in (or commit) offered this cycle.
- in_ready  output  1  the block accepts writes and commits this cycle.
- addr_mode  input  1  0 = streaming (auto-increment), 1 = addressed.
- addr  input  ADDR_W  target byte index in addressed mode; ignored in streaming mode.
- commit  input  1  addressed mode only: close the frame, qualified by in_ready.
- clear  input  1  abort the frame being loaded.
- data_out  output  NUM_BYTES*BYTE_W  output bank; byte i is at bits [i*BYTE_W +: BYTE_W].
- out_valid  output  1  data_out holds an unconsumed frame.
- out_ready  input  1  downstream accepts the frame.
- byte_count  output  ADDR_W  current streaming write pointer.
- addr_err  output  1  one-cycle pulse: an addressed write had addr >= NUM_BYTES.

## Operation
- **Storage**
  - Load bank L[0..NUM_BYTES-1] and output bank O[0..NUM_BYTES-1], both registered.
  - Write pointer wr_ptr.
  - State register: LOAD or PEND.
- **Reset** (rst==0 at the edge): L and O all zero, wr_ptr=0, state=LOAD, out_valid=0, addr_err=0.
- **Handshake**
  - in_ready = (state==LOAD).
  - A write is accepted when in_valid && in_ready.
  - A commit is accepted when commit && in_ready && addr_mode==1.
- **Streaming write** (addr_mode=0): L[wr_ptr] <= data_in.
  - If wr_ptr==NUM_BYTES-1, the frame is complete and wr_ptr <= 0.
  - Otherwise wr_ptr <= wr_ptr+1.
- **Addressed write** (addr_mode=1):
  - If addr < NUM_BYTES, L[addr] <= data_in.
  - Otherwise nothing is written and addr_err=1 for one cycle.
  - wr_ptr is unchanged.
  - An accepted commit completes the frame. A write and a commit in the same cycle place the written byte in the frame.
- **L persistence**: L is never cleared by a transfer. Addressed mode can therefore patch individual bytes of the previous frame, for example for a key update.
- **Completion**
  - If out_valid==0, or out_valid && out_ready in that cycle: O <= L, with the same-cycle write merged in. out_valid <= 1 and state stays LOAD.
  - Otherwise state <= PEND.
- **PEND**
  - in_ready=0.
  - When out_valid && out_ready: O <= L (out_valid stays 1), state <= LOAD.
- **Output consumption**: out_valid && out_ready with no transfer in the same cycle sets out_valid <= 0.
- **clear**
  - Sets wr_ptr <= 0. In PEND it drops the pending frame and sets state <= LOAD.
  - Has priority over a same-cycle write or commit; those are discarded and addr_err stays 0.
  - Does not modify L, O or out_valid.
- **Mode switch mid-frame**: allowed. A streaming pointer that was reached is kept, and addressed writes do not move it.

## Timing
- Write latency: byte accepted at edge k is in L after edge k and appears on data_out only after a transfer.
- Frame latency: completing edge k with the output bank free gives out_valid=1 and the new data_out from cycle k+1.
- Back-to-back: completing in the same cycle the output is consumed gives no bubble; out_valid stays 1 and data_out changes to the new frame.
- From PEND: out_ready at edge m loads O at edge m and gives in_ready=1 from cycle m+1.
- Stability: data_out and out_valid are stable while out_valid && !out_ready.
- addr_err is registered and high for exactly the cycle after the offending write.
- Reset mid-frame or mid-PEND returns every output to its reset value after that edge; any partial frame is lost.

## Test plan
- **Streaming fill** (NUM_BYTES=33, out_ready=1): bytes 0x00..0x20 streamed → out_valid=1 the cycle after the 33rd byte, data_out[7:0]=0x00, data_out[263:256]=0x20, byte_count=0.
- **Backpressure** (out_ready=0, NUM_BYTES=4): stream frames 0x11..0x14, then 0x21..0x24 → state PEND and in_ready=0. Third frame is stalled. Raise out_ready for 1 cycle → data_out=0x24232221 next cycle, in_ready=1.
- **Addressed patch**: addressed write addr=5 data=0xAB with commit in the same cycle → new frame equals the previous frame with byte 5=0xAB.
- **Bad address**: addr=40 write → no change to L, addr_err high for one cycle.
- **Clear**: clear after 10 streamed bytes → byte_count=0, out_valid unchanged, next 33 bytes form a clean frame. Clear with a commit in the same cycle → commit ignored.
- **Reset mid-frame**: rst=0 for one edge in PEND → out_valid=0, in_ready=1, data_out=0, byte_count=0.
